// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch-stage next-PC generator and its BHT.
package fetch_pc_unit_pkg;

  localparam int unsigned PC_WIDTH = 32;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t RESET_PC = '0;

  // 2-bit saturating branch counter encodings
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam bht_cnt_e BHT_RESET = WNT;

  // Saturating step of a 2-bit counter toward taken or not-taken.
  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
    if (taken) begin
      return (cur == ST) ? ST : cur + 2'd1;
    end else begin
      return (cur == SNT) ? SNT : cur - 2'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_pc_unit_bht_2bit.sv
// Untagged table of 2-bit saturating branch counters: one async read port,
// one synchronous update port, asynchronous active-low clear to weakly not-taken.
module bht_2bit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;

  logic [1:0] cnt_q [ENTRIES];

  // Read returns the pre-update value; a same-cycle write shows up next cycle.
  assign rd_taken = cnt_q[rd_idx][1];

  // Counter storage: clear all entries on reset, saturating update on resolve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= BHT_RESET;
      end
    end else if (upd_en) begin
      cnt_q[upd_idx] <= bht_next(cnt_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator: BTB+BHT prediction, execute-stage
// misprediction recovery with flush, and a saturating mispredict counter.
module fetch_pc_unit #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter int unsigned         IDX_W    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(fetch_pc_unit_pkg::RESET_PC),
  parameter int unsigned         CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_F,
  input  logic                btb_hit_F,
  input  logic [PC_WIDTH-1:0] btb_target_F,
  input  logic                resolve_valid_E,
  input  logic [PC_WIDTH-1:0] resolve_pc_E,
  input  logic                resolve_taken_E,
  input  logic [PC_WIDTH-1:0] resolve_target_E,
  input  logic                pred_taken_E,
  input  logic [PC_WIDTH-1:0] pred_target_E,
  output logic [PC_WIDTH-1:0] pc_F,
  output logic                pred_taken_F,
  output logic [PC_WIDTH-1:0] pred_target_F,
  output logic                flush_DE,
  output logic [CNT_W-1:0]    mispredict_cnt
);

  import fetch_pc_unit_pkg::*;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] recovery_pc;
  logic                bht_taken;
  logic                mispredict;
  logic [CNT_W-1:0]    cnt_q;

  bht_2bit #(
    .IDX_W (IDX_W)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_q[IDX_W-1:0]),
    .rd_taken  (bht_taken),
    .upd_en    (resolve_valid_E),
    .upd_idx   (resolve_pc_E[IDX_W-1:0]),
    .upd_taken (resolve_taken_E)
  );

  assign pc_plus1      = pc_q + PC_WIDTH'(1);
  assign pred_taken_F  = btb_hit_F & bht_taken;
  assign pred_target_F = pred_taken_F ? btb_target_F : pc_plus1;

  // A taken branch predicted taken can still be wrong if the target differs.
  assign mispredict = resolve_valid_E &
                      ((resolve_taken_E != pred_taken_E) |
                       (resolve_taken_E & pred_taken_E & (resolve_target_E != pred_target_E)));
  assign flush_DE   = mispredict;

  assign recovery_pc = resolve_taken_E ? resolve_target_E : resolve_pc_E + PC_WIDTH'(1);

  // Next-PC select: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = pred_target_F;
    if (mispredict) begin
      pc_d = recovery_pc;
    end else if (stall_F) begin
      pc_d = pc_q;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Misprediction performance counter, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (mispredict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pc_F           = pc_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes expected values,
// a monitor drains and compares them away from the rising clock edge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_F;
  logic        btb_hit_F;
  logic [31:0] btb_target_F;
  logic        resolve_valid_E;
  logic [31:0] resolve_pc_E;
  logic        resolve_taken_E;
  logic [31:0] resolve_target_E;
  logic        pred_taken_E;
  logic [31:0] pred_target_E;

  logic [31:0] pc_F, pred_target_F;
  logic        pred_taken_F, flush_DE;
  logic [15:0] mispredict_cnt;

  logic [31:0] pc_F4, pred_target_F4;
  logic        pred_taken_F4, flush_DE4;
  logic [3:0]  mispredict_cnt4;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall_F          (stall_F),
    .btb_hit_F        (btb_hit_F),
    .btb_target_F     (btb_target_F),
    .resolve_valid_E  (resolve_valid_E),
    .resolve_pc_E     (resolve_pc_E),
    .resolve_taken_E  (resolve_taken_E),
    .resolve_target_E (resolve_target_E),
    .pred_taken_E     (pred_taken_E),
    .pred_target_E    (pred_target_E),
    .pc_F             (pc_F),
    .pred_taken_F     (pred_taken_F),
    .pred_target_F    (pred_target_F),
    .flush_DE         (flush_DE),
    .mispredict_cnt   (mispredict_cnt)
  );

  // Narrow-counter copy driven by the same stimulus, for saturation.
  fetch_pc_unit #(
    .CNT_W (4)
  ) dut4 (
    .clk              (clk),
    .reset            (reset),
    .stall_F          (stall_F),
    .btb_hit_F        (btb_hit_F),
    .btb_target_F     (btb_target_F),
    .resolve_valid_E  (resolve_valid_E),
    .resolve_pc_E     (resolve_pc_E),
    .resolve_taken_E  (resolve_taken_E),
    .resolve_target_E (resolve_target_E),
    .pred_taken_E     (pred_taken_E),
    .pred_target_E    (pred_target_E),
    .pc_F             (pc_F4),
    .pred_taken_F     (pred_taken_F4),
    .pred_target_F    (pred_target_F4),
    .flush_DE         (flush_DE4),
    .mispredict_cnt   (mispredict_cnt4)
  );

  typedef enum int {FPc, FPt, FPtgt, FFlush, FCnt, FCnt4} fld_e;

  typedef struct {
    string       name;
    fld_e        fld;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  event mon_ev;

  task automatic chk(input string n, input fld_e f, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.fld  = f;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] rpc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    resolve_valid_E  = 1'b1;
    resolve_pc_E     = rpc;
    resolve_taken_E  = tk;
    resolve_target_E = tgt;
    pred_taken_E     = ptk;
    pred_target_E    = ptgt;
  endtask

  task automatic idle();
    resolve_valid_E = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the live DUT outputs.
  always @(negedge clk or mon_ev) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.fld)
        FPc:     act = pc_F;
        FPt:     act = {31'd0, pred_taken_F};
        FPtgt:   act = pred_target_F;
        FFlush:  act = {31'd0, flush_DE};
        FCnt:    act = {16'd0, mispredict_cnt};
        default: act = {28'd0, mispredict_cnt4};
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; stall_F = 1'b0; btb_hit_F = 1'b0; btb_target_F = '0;
    resolve_valid_E = 1'b0; resolve_pc_E = '0; resolve_taken_E = 1'b0;
    resolve_target_E = '0; pred_taken_E = 1'b0; pred_target_E = '0;

    // Reset state
    cyc();
    chk("rst_pc", FPc, 0); chk("rst_pt", FPt, 0); chk("rst_flush", FFlush, 0);
    chk("rst_cnt", FCnt, 0);
    reset = 1'b1;

    // Sequential fetch
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk($sformatf("seq_pc%0d", i), FPc, i);
      chk($sformatf("seq_pt%0d", i), FPt, 0);
      chk($sformatf("seq_flush%0d", i), FFlush, 0);
    end

    // BTB hit on weakly-not-taken entry; concurrent training uses old value
    cyc();
    chk("pc4", FPc, 4);
    btb_hit_F = 1'b1; btb_target_F = 32'h20;
    resolve(4, 1, 32'h20, 1, 32'h20);
    chk("wnt_pt", FPt, 0); chk("wnt_ptgt", FPtgt, 5); chk("train_flush", FFlush, 0);
    cyc();
    chk("pc5", FPc, 5);
    btb_hit_F = 1'b0;
    resolve(4, 1, 32'h20, 1, 32'h20);
    // Not-taken mispredict redirects back to 4
    cyc();
    chk("pc6", FPc, 6);
    resolve(3, 0, 0, 1, 32'h99);
    chk("nt_flush", FFlush, 1); chk("cnt0", FCnt, 0);
    cyc();
    chk("redir_pc4", FPc, 4); chk("cnt1", FCnt, 1);
    idle(); btb_hit_F = 1'b1; btb_target_F = 32'h20;
    chk("st_pt", FPt, 1); chk("st_ptgt", FPtgt, 32'h20); chk("noresolve_flush", FFlush, 0);

    // Mispredict overrides stall
    cyc();
    chk("taken_pc20", FPc, 32'h20);
    btb_hit_F = 1'b0; stall_F = 1'b1;
    resolve(32'h10, 0, 0, 1, 32'h77);
    chk("stall_mp_flush", FFlush, 1);
    cyc();
    chk("stall_mp_pc", FPc, 32'h11); chk("cnt2", FCnt, 2);
    idle();
    chk("one_flush", FFlush, 0);
    cyc();
    chk("stall_hold", FPc, 32'h11);
    stall_F = 1'b0;

    // Taken with wrong target
    resolve(32'h40, 1, 32'h24, 1, 32'h20);
    chk("tgt_flush", FFlush, 1);
    cyc();
    chk("tgt_pc", FPc, 32'h24); chk("cnt3", FCnt, 3);
    resolve(32'h2A, 0, 0, 0, 0);
    chk("nt_ok_flush", FFlush, 0);
    cyc();
    chk("seq_pc25", FPc, 32'h25);
    idle();

    // Saturate BHT[7] with taken resolves
    for (int i = 0; i < 12; i++) begin
      cyc();
      resolve(7, 1, 32'h70, 1, 32'h70);
      chk($sformatf("sat_flush%0d", i), FFlush, 0);
    end
    cyc();
    resolve(6, 0, 0, 1, 32'h70);
    chk("to7_flush", FFlush, 1);
    cyc();
    chk("pc7", FPc, 7);
    idle(); btb_hit_F = 1'b1; btb_target_F = 32'h99;
    chk("sat_pt", FPt, 1); chk("sat_ptgt", FPtgt, 32'h99); chk("cnt4", FCnt, 4);
    cyc();
    chk("pc99", FPc, 32'h99);
    btb_hit_F = 1'b0;

    // 100 consecutive mispredicts
    for (int i = 0; i < 100; i++) begin
      cyc();
      resolve(32'h100, 0, 0, 1, 0);
      chk($sformatf("mp_flush%0d", i), FFlush, 1);
    end
    cyc();
    chk("mp_pc", FPc, 32'h101); chk("cnt104", FCnt, 104); chk("cnt4_sat", FCnt4, 15);

    // PC wrap at all-ones
    resolve(5, 1, 32'hFFFF_FFFF, 0, 0);
    cyc();
    chk("pc_max", FPc, 32'hFFFF_FFFF); chk("cnt105", FCnt, 105);
    idle();
    chk("wrap_ptgt", FPtgt, 0);
    cyc();
    chk("pc_wrap", FPc, 0);
    resolve(32'hFFFF_FFFF, 0, 0, 1, 0);
    chk("recwrap_flush", FFlush, 1);
    cyc();
    chk("rec_wrap_pc", FPc, 0); chk("cnt106", FCnt, 106);
    resolve(8, 1, 32'h33, 0, 0);
    cyc();
    chk("pc33", FPc, 32'h33);
    idle(); stall_F = 1'b1;

    // Async reset between edges
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (pc_F !== 32'd0) begin
      failures++;
      $display("FAIL arst_pc_direct: got 0x%0h expected 0x0 at %0t", pc_F, $time);
    end
    checks++;
    if (mispredict_cnt !== 16'd0) begin
      failures++;
      $display("FAIL arst_cnt_direct: got 0x%0h expected 0x0 at %0t", mispredict_cnt, $time);
    end
    checks++;
    if (mispredict_cnt4 !== 4'd0) begin
      failures++;
      $display("FAIL arst_cnt4_direct: got 0x%0h expected 0x0 at %0t", mispredict_cnt4, $time);
    end
    checks++;
    if (flush_DE !== 1'b0) begin
      failures++;
      $display("FAIL arst_flush_direct: got 0x%0h expected 0x0 at %0t", flush_DE, $time);
    end
    checks++;
    if (pred_taken_F !== 1'b0) begin
      failures++;
      $display("FAIL arst_pt_direct: got 0x%0h expected 0x0 at %0t", pred_taken_F, $time);
    end
    chk("arst_pc", FPc, 0); chk("arst_cnt", FCnt, 0); chk("arst_cnt4", FCnt4, 0);
    chk("arst_flush", FFlush, 0); chk("arst_pt", FPt, 0);
    -> mon_ev;

    // Release and sweep all BHT entries with a BTB hit
    cyc();
    reset = 1'b1; stall_F = 1'b0; btb_hit_F = 1'b1; btb_target_F = 32'h500;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cyc();
      chk($sformatf("sweep_pc%0d", i), FPc, i);
      chk($sformatf("sweep_pt%0d", i), FPt, 0);
      if (i == 15) resolve(0, 1, 32'h500, 1, 32'h500);
    end
    // One taken step from WNT must reach WT
    cyc();
    chk("wnt_step_pc", FPc, 16);
    idle();
    chk("wnt_step_pt", FPt, 1); chk("wnt_step_ptgt", FPtgt, 32'h500);
    cyc();
    chk("final_pc", FPc, 32'h500);
    btb_hit_F = 1'b0;

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
